// File: rtl/soc_system_clkdiv_pkg.sv
// Shared types and the effective-configuration helper for the clock divider bank.
package soc_system_clkdiv_pkg;

  localparam int unsigned CFG_W = 32;

  typedef enum logic [1:0] {
    SYNC,
    SETTLE,
    LOCKED
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } clk_cfg_t;

  typedef enum logic [1:0] {
    HIGH_RAW,
    HIGH_ONE,
    HIGH_MAX
  } high_sel_e;

  typedef struct packed {
    logic      en;
    high_sel_e high_sel;
    logic      phase_keep;
  } eff_sel_t;

  // Returns selections rather than values so each channel applies them at its own width.
  function automatic eff_sel_t eff_cfg(input clk_cfg_t raw);
    eff_sel_t s;
    s.en         = (raw.div >= CFG_W'(2));
    s.phase_keep = (raw.phase < raw.div);
    if (raw.high == '0)
      s.high_sel = HIGH_ONE;
    else if (raw.high >= raw.div)
      s.high_sel = HIGH_MAX;
    else
      s.high_sel = HIGH_RAW;
    return s;
  endfunction

endpackage

// File: rtl/soc_system_clkdiv_chan.sv
// One divider channel: shadow config, phase counter, registered outclk and tick.
module soc_system_clkdiv_chan
  import soc_system_clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             sync_load,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             outclk,
  output logic             outclk_tick
);

  logic             en_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] high_q;
  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] cnt_q;
  eff_sel_t         sel;

  always_comb begin
    sel = eff_cfg(clk_cfg_t'{div:   CFG_W'(cfg_div),
                             high:  CFG_W'(cfg_high),
                             phase: CFG_W'(cfg_phase)});
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b1;
      div_q       <= DIV_W'(DEFAULT_DIV);
      high_q      <= DIV_W'(DEFAULT_DIV / 2);
      phase_q     <= '0;
      cnt_q       <= '0;
      outclk      <= 1'b0;
      outclk_tick <= 1'b0;
    end else begin
      if (cfg_we) begin
        en_q    <= sel.en;
        div_q   <= cfg_div;
        phase_q <= sel.phase_keep ? cfg_phase : '0;
        case (sel.high_sel)
          HIGH_ONE: high_q <= DIV_W'(1);
          HIGH_MAX: high_q <= cfg_div - DIV_W'(1);
          default:  high_q <= cfg_high;
        endcase
      end

      if (sync_load) begin
        cnt_q       <= phase_q;
        outclk      <= 1'b0;
        outclk_tick <= 1'b0;
      end else if (en_q) begin
        cnt_q       <= (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
        outclk      <= (cnt_q < high_q);
        outclk_tick <= (cnt_q == '0);
      end else begin
        cnt_q       <= '0;
        outclk      <= 1'b0;
        outclk_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/soc_system_clkdiv_bank.sv
// Bank of programmable clock dividers with a shared resync/settle/lock sequencer.
module soc_system_clkdiv_bank
  import soc_system_clkdiv_pkg::*;
#(
  parameter  int unsigned NUM_CLOCKS  = 4,
  parameter  int unsigned DIV_W       = 16,
  parameter  int unsigned LOCK_CYCLES = 16,
  parameter  int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CHAN_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_tick,
  output logic                  locked
);

  localparam int unsigned SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_CYCLES - 1);

  state_e                state_q;
  logic [SW-1:0]         settle_q;
  logic                  chan_ok;
  logic                  accept_hit;
  logic                  sync_load;
  logic [NUM_CLOCKS-1:0] cfg_we;

  // Out-of-range channels still handshake but never trigger a resync.
  assign chan_ok    = (32'(cfg_chan) < 32'(NUM_CLOCKS));
  assign accept_hit = cfg_valid && cfg_ready && chan_ok;
  assign sync_load  = (state_q == SYNC);

  always_comb begin
    cfg_we = '0;
    for (int unsigned i = 0; i < NUM_CLOCKS; i++)
      cfg_we[i] = accept_hit && (32'(cfg_chan) == i);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      settle_q  <= '0;
      cfg_ready <= 1'b0;
      locked    <= 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          state_q   <= SETTLE;
          settle_q  <= '0;
          cfg_ready <= 1'b1;
          locked    <= 1'b0;
        end
        SETTLE: begin
          if (accept_hit) begin
            state_q   <= SYNC;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
          end else if (settle_q == SETTLE_LAST) begin
            state_q <= LOCKED;
            locked  <= 1'b1;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        LOCKED: begin
          if (accept_hit) begin
            state_q   <= SYNC;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
          end
        end
        default: begin
          state_q   <= SYNC;
          cfg_ready <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    soc_system_clkdiv_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .refclk      (refclk),
      .rst_n       (rst_n),
      .sync_load   (sync_load),
      .cfg_we      (cfg_we[g]),
      .cfg_div     (cfg_div),
      .cfg_high    (cfg_high),
      .cfg_phase   (cfg_phase),
      .outclk      (outclk[g]),
      .outclk_tick (outclk_tick[g])
    );
  end

endmodule

// File: tb/tb_soc_system_clkdiv_bank.sv
// Directed bench for the clock divider bank: lock sequence, reconfig, boundaries, reset.
module tb_soc_system_clkdiv_bank;

  localparam int unsigned NCLK  = 5;
  localparam int unsigned DIV_W = 16;

  logic             refclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [2:0]       cfg_chan = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [DIV_W-1:0] cfg_high = '0;
  logic [DIV_W-1:0] cfg_phase = '0;
  logic [NCLK-1:0]  outclk;
  logic [NCLK-1:0]  outclk_tick;
  logic             locked;

  int total = 0;
  int passed = 0;
  int m = 0;
  int rise0 = -1;
  int rise2 = -1;
  int m_div[NCLK];
  int m_high[NCLK];
  int m_phase[NCLK];
  int accepts;
  int wdiv[3];
  int whigh[3];
  int wphase[3];
  int wchan[3];
  bit acc;

  soc_system_clkdiv_bank #(
    .NUM_CLOCKS  (NCLK),
    .DIV_W       (DIV_W),
    .LOCK_CYCLES (16),
    .DEFAULT_DIV (2)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_phase   (cfg_phase),
    .outclk      (outclk),
    .outclk_tick (outclk_tick),
    .locked      (locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    m++;
  endtask

  task automatic set_model(input int ch, input int d, input int h, input int p);
    m_div[ch]   = d;
    m_high[ch]  = h;
    m_phase[ch] = p;
  endtask

  task automatic defaults();
    for (int ch = 0; ch < NCLK; ch++) set_model(ch, 2, 1, 0);
  endtask

  // Expected vectors m cycles after the SYNC cycle, from effective div/high/phase.
  function automatic logic [NCLK-1:0] exp_vec(input bit want_tick);
    logic [NCLK-1:0] v;
    int r;
    v = '0;
    for (int ch = 0; ch < NCLK; ch++) begin
      if (m >= 2 && m_div[ch] >= 2) begin
        r = (m_phase[ch] + m - 2) % m_div[ch];
        v[ch] = want_tick ? (r == 0) : (r < m_high[ch]);
      end
    end
    return v;
  endfunction

  task automatic observe(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s m=%0d outclk", tag, m), 32'(outclk), 32'(exp_vec(1'b0)));
      chk($sformatf("%s m=%0d tick", tag, m), 32'(outclk_tick), 32'(exp_vec(1'b1)));
      chk($sformatf("%s m=%0d locked", tag, m), 32'(locked), (m >= 17) ? 32'd1 : 32'd0);
      chk($sformatf("%s m=%0d cfg_ready", tag, m), 32'(cfg_ready), 32'd1);
      if (outclk_tick[0] && rise0 < 0) rise0 = m;
      if (outclk_tick[2] && rise2 < 0) rise2 = m;
    end
  endtask

  task automatic mark_sync();
    m = 0;
    rise0 = -1;
    rise2 = -1;
  endtask

  task automatic cfg_write(input int ch, input int d, input int h, input int p, input bit valid_ch);
    cfg_chan  = 3'(ch);
    cfg_div   = DIV_W'(d);
    cfg_high  = DIV_W'(h);
    cfg_phase = DIV_W'(p);
    cfg_valid = 1'b1;
    for (int i = 0; i < 40 && cfg_ready !== 1'b1; i++) step();
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    if (valid_ch) begin
      mark_sync();
      chk("sync locked", 32'(locked), 32'd0);
      chk("sync cfg_ready", 32'(cfg_ready), 32'd0);
    end
  endtask

  task automatic chk_lead(input string tag);
    chk(tag, 32'((rise0 - rise2 + 8) % 8), 32'd3);
  endtask

  initial begin
    defaults();
    #2;
    chk("rst outclk", 32'(outclk), 32'd0);
    chk("rst tick", 32'(outclk_tick), 32'd0);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst cfg_ready", 32'(cfg_ready), 32'd0);
    @(posedge refclk);
    #1;
    rst_n = 1'b1;
    mark_sync();
    chk("boot sync cfg_ready", 32'(cfg_ready), 32'd0);
    observe("boot", 17);

    cfg_write(1, 5, 2, 0, 1'b1);
    set_model(1, 5, 2, 0);
    observe("ch1_div5", 17);

    cfg_write(0, 8, 4, 0, 1'b1);
    set_model(0, 8, 4, 0);
    observe("ch0_div8", 17);
    cfg_write(2, 8, 4, 3, 1'b1);
    set_model(2, 8, 4, 3);
    observe("ch2_ph3", 17);
    chk_lead("lead ch2_ph3");

    cfg_write(3, 1, 1, 0, 1'b1);
    set_model(3, 1, 0, 0);
    observe("div1_off", 17);
    chk_lead("lead div1_off");
    cfg_write(4, 4, 9, 0, 1'b1);
    set_model(4, 4, 3, 0);
    observe("high_clamp", 17);
    cfg_write(3, 4, 2, 6, 1'b1);
    set_model(3, 4, 2, 0);
    observe("phase_wrap", 17);

    cfg_write(7, 3, 1, 0, 1'b0);
    chk("bad_chan locked", 32'(locked), 32'd1);
    chk("bad_chan cfg_ready", 32'(cfg_ready), 32'd1);
    observe("bad_chan", 6);

    // Three requests with cfg_valid held high throughout.
    wchan[0] = 0; wdiv[0] = 8; whigh[0] = 4; wphase[0] = 0;
    wchan[1] = 2; wdiv[1] = 8; whigh[1] = 4; wphase[1] = 3;
    wchan[2] = 1; wdiv[2] = 6; whigh[2] = 3; wphase[2] = 0;
    accepts = 0;
    cfg_chan = 3'(wchan[0]); cfg_div = DIV_W'(wdiv[0]);
    cfg_high = DIV_W'(whigh[0]); cfg_phase = DIV_W'(wphase[0]);
    cfg_valid = 1'b1;
    for (int i = 0; i < 20 && accepts < 3; i++) begin
      acc = cfg_ready;
      step();
      if (acc) begin
        accepts++;
        chk($sformatf("held sync%0d cfg_ready", accepts), 32'(cfg_ready), 32'd0);
        chk($sformatf("held sync%0d locked", accepts), 32'(locked), 32'd0);
        if (accepts < 3) begin
          cfg_chan = 3'(wchan[accepts]); cfg_div = DIV_W'(wdiv[accepts]);
          cfg_high = DIV_W'(whigh[accepts]); cfg_phase = DIV_W'(wphase[accepts]);
        end else begin
          cfg_valid = 1'b0;
        end
      end else begin
        chk("held settle locked", 32'(locked), 32'd0);
      end
    end
    chk("held accepts", 32'(accepts), 32'd3);
    mark_sync();
    set_model(1, 6, 3, 0);
    observe("held_after", 17);
    chk_lead("lead held_after");

    cfg_write(4, 6, 2, 1, 1'b1);
    set_model(4, 6, 2, 1);
    observe("pre_rst", 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async outclk", 32'(outclk), 32'd0);
    chk("async tick", 32'(outclk_tick), 32'd0);
    chk("async locked", 32'(locked), 32'd0);
    chk("async cfg_ready", 32'(cfg_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    mark_sync();
    defaults();
    observe("post_rst", 17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
